// File: rtl/decoder_3to8.sv
// Registered 3-to-8 line decoder: one-hot (or one-cold with ACTIVE_LOW=1)
// output word selected by a 3-bit binary index, one cycle of latency.
module decoder_3to8 #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in,
  output logic [7:0] out
);

  localparam logic [7:0] RESET_VALUE = ACTIVE_LOW ? 8'hFF : 8'h00;

  function automatic logic [7:0] decode_onehot(input logic [2:0] sel);
    decode_onehot = 8'b0000_0001 << sel;
  endfunction

  logic [7:0] decode_s;
  logic [7:0] out_r;

  // Polarity-adjusted decode of the current select value.
  always_comb begin
    decode_s = RESET_VALUE;
    if (ACTIVE_LOW) begin
      decode_s = ~decode_onehot(in);
    end else begin
      decode_s = decode_onehot(in);
    end
  end

  // Output register; reset wins over any select change in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= RESET_VALUE;
    end else begin
      out_r <= decode_s;
    end
  end

  assign out = out_r;

endmodule

// File: tb/tb_decoder_3to8.sv
// Scoreboard bench for decoder_3to8: drives both polarity builds from the
// same stimulus and compares each against a table-based reference model.
module tb_decoder_3to8;

  logic       clk;
  logic       rst;
  logic [2:0] in_s;
  logic [7:0] out_hi;
  logic [7:0] out_lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_hi_q[$];
  logic [7:0] exp_lo_q[$];

  decoder_3to8 #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk (clk),
    .rst (rst),
    .in  (in_s),
    .out (out_hi)
  );

  decoder_3to8 #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk (clk),
    .rst (rst),
    .in  (in_s),
    .out (out_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_hi(input logic r, input logic [2:0] v);
    logic [7:0] m;
    if (r) begin
      m = 8'h00;
    end else begin
      case (v)
        3'd0:    m = 8'h01;
        3'd1:    m = 8'h02;
        3'd2:    m = 8'h04;
        3'd3:    m = 8'h08;
        3'd4:    m = 8'h10;
        3'd5:    m = 8'h20;
        3'd6:    m = 8'h40;
        3'd7:    m = 8'h80;
        default: m = 8'hxx;
      endcase
    end
    return m;
  endfunction

  function automatic logic [7:0] model_lo(input logic r, input logic [2:0] v);
    return r ? 8'hFF : ~model_hi(1'b0, v);
  endfunction

  // Drive one cycle of stimulus at the falling edge, check just after the rising edge.
  task automatic step(input string tag, input logic r, input logic [2:0] v);
    logic [7:0] e_hi;
    logic [7:0] e_lo;
    @(negedge clk);
    rst  = r;
    in_s = v;
    exp_hi_q.push_back(model_hi(r, v));
    exp_lo_q.push_back(model_lo(r, v));
    @(posedge clk);
    #1;
    if (exp_hi_q.size() == 0 || exp_lo_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 8'h01, 8'h00);
    end else begin
      e_hi = exp_hi_q.pop_front();
      e_lo = exp_lo_q.pop_front();
      check_eq({tag, "_hi"}, out_hi, e_hi);
      check_eq({tag, "_lo"}, out_lo, e_lo);
    end
    if (!r) begin
      check_eq({tag, "_onehot"}, {7'd0, $onehot(out_hi)}, 8'h01);
      check_eq({tag, "_onecold"}, {7'd0, $onehot(~out_lo)}, 8'h01);
    end
  endtask

  initial begin
    rst  = 1'b1;
    in_s = 3'd0;

    // Reset, with select changing while held in reset
    step("rst_in5", 1'b1, 3'd5);
    step("rst_hold", 1'b1, 3'd2);

    // Full sweep
    for (int i = 0; i < 8; i++) begin
      step($sformatf("sweep%0d", i), 1'b0, 3'(i));
    end

    // Wrap-around 6,7,0,1
    step("wrap6", 1'b0, 3'd6);
    step("wrap7", 1'b0, 3'd7);
    step("wrap0", 1'b0, 3'd0);
    step("wrap1", 1'b0, 3'd1);

    // Latency: a mid-cycle select change must not reach out before the next edge
    step("lat4", 1'b0, 3'd4);
    #2;
    in_s = 3'd1;
    #1;
    check_eq("lat_mid_hi", out_hi, 8'h10);
    check_eq("lat_mid_lo", out_lo, 8'hEF);
    #5;
    check_eq("lat_late_hi", out_hi, 8'h10);
    step("lat1", 1'b0, 3'd1);

    // Mid-run reset pulse
    step("mid3", 1'b0, 3'd3);
    step("mid_rst", 1'b1, 3'd3);
    step("mid_post", 1'b0, 3'd3);

    // Reset immediately followed by a different select
    step("rst_again", 1'b1, 3'd7);
    step("post_rst7", 1'b0, 3'd7);

    check_eq("sb_drained", 8'(exp_hi_q.size() + exp_lo_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
